bolme_sonuc_bcd: RTL and testbench
==================================

// Module: bolme_sonuc_bcd
// PURPOSE
//  Result stage directly downstream of the bolme divider.
//  - Captures bolum/kalan when the divider's done rises.
//  - Converts each value serially to packed BCD (double-dabble, one bit per clock).
//  - Presents both BCD words plus a one-cycle valid strobe to the display/report stage.
//  - Maps divisor_zero to an error code instead of a numeric result.
// PARAMETERS
//  W       4  width of bolum/kalan from the divider
//  DIGITS  2  BCD digits per value; must satisfy 10**DIGITS > 2**W-1
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  done          in   1         divider done (level, may stay high several cycles)
//  divisor_zero  in   1         divider error flag, qualified by done
//  bolum         in   W         quotient from divider
//  kalan         in   W         remainder from divider
//  bolum_bcd     out  4*DIGITS  packed BCD quotient, digit 0 in [3:0]
//  kalan_bcd     out  4*DIGITS  packed BCD remainder
//  valid         out  1         one-cycle strobe: *_bcd and err updated this cycle
//  err           out  1         1 = last result was divide-by-zero
//  busy          out  1         conversion in progress (state != IDLE)
// BEHAVIOUR
//  Reset (async, rst=1):
//  - state=IDLE, done_q=0, shift counter=0.
//  - bolum_bcd=0, kalan_bcd=0, valid=0, err=0, busy=0.
//  Trigger: done_rise = done & ~done_q; done_q registered every cycle.
//  FSM states: IDLE, SHIFT, OUT.
//  - IDLE, done_rise, divisor_zero=0:
//    load bin regs <= bolum/kalan, clear BCD accumulators, cnt <= 0, go SHIFT.
//  - IDLE, done_rise, divisor_zero=1:
//    go OUT with err_next=1; no conversion.
//  - SHIFT, each cycle:
//    add 3 to every accumulator digit >= 5, then shift {acc,bin} left by 1.
//    cnt++; after W shifts (cnt==W-1), go OUT.
//  - OUT, one cycle:
//    *_bcd <= accumulators, or all digits 4'hF when err_next.
//    err <= err_next, valid=1, go IDLE.
//  Latency:
//  - done_rise sampled at edge k -> valid high in cycle after edge k+W+1.
//  - Divide-by-zero -> valid one cycle after edge k.
//  Outputs:
//  - *_bcd and err hold their value until the next OUT.
//  - valid is 0 in all other cycles.
//  Boundaries:
//  - done held high: only one conversion (edge detect).
//  - done_rise while busy: ignored, no queueing; current conversion completes unchanged.
//  - done_rise in the OUT cycle: ignored (busy=1).
//  - bolum/kalan changing during SHIFT: no effect (captured at load).
//  - Max input 2**W-1 must convert exactly; 0 converts to all-zero digits.
//  - rst mid-conversion: immediate return to reset values, no valid issued.
// STRUCTURE
//  Shared package (bolme_pkg):
//  - state encoding localparams (IDLE/SHIFT/OUT).
//  - BCD_HATA nibble constant (4'hF).
//  - clog2-style counter-width function.
//  Sub-module bcd_seri_donusturucu:
//  - single-value serial double-dabble (load, step, bcd out).
//  - instantiated twice (bolum, kalan); FSM, edge detect and output regs stay in top.
// TESTING (W=4, DIGITS=2, 10 ns clock)
//  1) 15/2 (bolum=7, kalan=1), done pulse
//     -> valid after W+2 cycles, bolum_bcd=8'h07, kalan_bcd=8'h01, err=0.
//  2) bolum=15, kalan=0
//     -> bolum_bcd=8'h15, kalan_bcd=8'h00; then bolum=9, kalan=6 -> 8'h09 / 8'h06.
//  3) divisor_zero=1 with done
//     -> valid next cycle, err=1, bolum_bcd=kalan_bcd=8'hFF; next good result clears err.
//  4) done held high 5 cycles
//     -> exactly one valid pulse; busy high W+1 cycles.
//  5) second done rise during SHIFT (new operands)
//     -> ignored; single valid carrying the first operands' BCD.
//  6) rst asserted mid-SHIFT
//     -> outputs 0 immediately, no valid; next done after release converts correctly.

Source files
------------

// File: rtl/bolme_pkg.sv
// Shared definitions for the divider result stage: state encoding,
// error nibble and counter sizing helper.
package bolme_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    // Shown on every digit when the divider flagged a zero divisor.
    localparam logic [3:0] BCD_HATA = 4'hF;

    function automatic int sayac_genislik(input int n);
        int g;
        g = 1;
        while ((1 << g) < n) g++;
        return g;
    endfunction

endpackage

// File: rtl/bcd_seri_donusturucu.sv
// Single-value serial double-dabble: load captures the binary value and
// clears the accumulator, each step adds 3 to digits >= 5 then shifts once.
module bcd_seri_donusturucu
    import bolme_pkg::*;
#(
    parameter int W      = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [W-1:0]          i_bin,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int AW = 4 * DIGITS;

    logic [AW-1:0]   r_acc;
    logic [W-1:0]    r_bin;
    logic [AW-1:0]   w_adj;
    logic [AW+W-1:0] w_cat;

    always_comb begin
        w_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        end
        w_cat = {w_adj, r_bin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_bin <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_bin <= i_bin;
        end else if (i_step) begin
            {r_acc, r_bin} <= {w_cat[AW+W-2:0], 1'b0};
        end
    end

    assign o_bcd = r_acc;

endmodule

// File: rtl/bolme_sonuc_bcd.sv
// Result stage behind the divider: edge-detects done, converts quotient and
// remainder to packed BCD serially, and publishes them with a valid strobe.
module bolme_sonuc_bcd
    import bolme_pkg::*;
#(
    parameter int W      = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done,
    input  logic                divisor_zero,
    input  logic [W-1:0]        bolum,
    input  logic [W-1:0]        kalan,
    output logic [4*DIGITS-1:0] bolum_bcd,
    output logic [4*DIGITS-1:0] kalan_bcd,
    output logic                valid,
    output logic                err,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int CW = sayac_genislik(W);

    logic [1:0]          r_state;
    logic                r_done_q;
    logic [CW-1:0]       r_cnt;
    logic                r_err_next;
    logic [4*DIGITS-1:0] r_bolum_bcd;
    logic [4*DIGITS-1:0] r_kalan_bcd;
    logic                r_valid;
    logic                r_err;

    logic                w_done_rise;
    logic                w_load;
    logic                w_step;
    logic [4*DIGITS-1:0] w_bolum_acc;
    logic [4*DIGITS-1:0] w_kalan_acc;

    assign w_done_rise = done & ~r_done_q;
    assign w_load      = (r_state == ST_IDLE) & w_done_rise & ~divisor_zero;
    assign w_step      = (r_state == ST_SHIFT);

    bcd_seri_donusturucu #(.W(W), .DIGITS(DIGITS)) u_bolum (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
        .i_bin(bolum), .o_bcd(w_bolum_acc)
    );

    bcd_seri_donusturucu #(.W(W), .DIGITS(DIGITS)) u_kalan (
        .clk(clk), .rst(rst), .i_load(w_load), .i_step(w_step),
        .i_bin(kalan), .o_bcd(w_kalan_acc)
    );

    // valid is a one-cycle strobe with no back-pressure: the consumer must take
    // *_bcd/err in the cycle valid is high; they then hold until the next strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done_q    <= 1'b0;
            r_cnt       <= '0;
            r_err_next  <= 1'b0;
            r_bolum_bcd <= '0;
            r_kalan_bcd <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done_q <= done;
            r_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_done_rise) begin
                        r_err_next <= divisor_zero;
                        r_cnt      <= '0;
                        r_state    <= divisor_zero ? ST_OUT : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1))
                        r_state <= ST_OUT;
                end
                ST_OUT: begin
                    r_bolum_bcd <= r_err_next ? {DIGITS{BCD_HATA}} : w_bolum_acc;
                    r_kalan_bcd <= r_err_next ? {DIGITS{BCD_HATA}} : w_kalan_acc;
                    r_err       <= r_err_next;
                    r_valid     <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bolum_bcd = r_bolum_bcd;
    assign kalan_bcd = r_kalan_bcd;
    assign valid     = r_valid;
    assign err       = r_err;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bolme_sonuc_bcd.sv
// Directed bench for bolme_sonuc_bcd: vector table plus hand-written
// sequences for held done, overlapping done and mid-conversion reset.
module tb_bolme_sonuc_bcd;

    localparam int W = 4;
    localparam int DIGITS = 2;
    localparam int LAT_OK = W + 2;
    localparam int LAT_DZ = 2;

    logic       clk;
    logic       rst;
    logic       done;
    logic       divisor_zero;
    logic [3:0] bolum;
    logic [3:0] kalan;
    logic [7:0] bolum_bcd;
    logic [7:0] kalan_bcd;
    logic       valid;
    logic       err;
    logic       busy;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] b;
        logic [3:0] k;
        logic       dz;
        logic [7:0] eb;
        logic [7:0] ek;
        logic       ee;
    } vec_t;

    vec_t vecs[8];

    bolme_sonuc_bcd #(.W(W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .done(done), .divisor_zero(divisor_zero),
        .bolum(bolum), .kalan(kalan), .bolum_bcd(bolum_bcd), .kalan_bcd(kalan_bcd),
        .valid(valid), .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch one done pulse and wait (bounded) for the valid strobe.
    task automatic send(input logic [3:0] b, input logic [3:0] k, input logic dz, output int lat);
        @(negedge clk);
        bolum = b; kalan = k; divisor_zero = dz; done = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            done = 1'b0;
            lat++;
        end while (!valid && lat < 20);
    endtask

    task automatic run_vec(input int idx);
        int lat;
        send(vecs[idx].b, vecs[idx].k, vecs[idx].dz, lat);
        chk($sformatf("v%0d_valid", idx), {31'd0, valid}, 32'd1);
        chk($sformatf("v%0d_latency", idx), lat, vecs[idx].dz ? LAT_DZ : LAT_OK);
        chk($sformatf("v%0d_bolum_bcd", idx), {24'd0, bolum_bcd}, {24'd0, vecs[idx].eb});
        chk($sformatf("v%0d_kalan_bcd", idx), {24'd0, kalan_bcd}, {24'd0, vecs[idx].ek});
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, vecs[idx].ee});
        @(negedge clk);
        chk($sformatf("v%0d_valid_drop", idx), {31'd0, valid}, 32'd0);
        chk($sformatf("v%0d_hold_bolum", idx), {24'd0, bolum_bcd}, {24'd0, vecs[idx].eb});
    endtask

    initial begin
        int n_valid;
        int n_busy;
        int lat;
        logic [7:0] cap_b;
        logic [7:0] cap_k;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; done = 1'b0; divisor_zero = 1'b0; bolum = '0; kalan = '0;

        vecs[0] = '{4'd7,  4'd1, 1'b0, 8'h07, 8'h01, 1'b0};
        vecs[1] = '{4'd15, 4'd0, 1'b0, 8'h15, 8'h00, 1'b0};
        vecs[2] = '{4'd9,  4'd6, 1'b0, 8'h09, 8'h06, 1'b0};
        vecs[3] = '{4'd3,  4'd2, 1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{4'd10, 4'd5, 1'b0, 8'h10, 8'h05, 1'b0};
        vecs[5] = '{4'd0,  4'd0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{4'd12, 4'd15, 1'b0, 8'h12, 8'h15, 1'b0};
        vecs[7] = '{4'd11, 4'd3, 1'b1, 8'hFF, 8'hFF, 1'b1};

        #12;
        chk("rst_bolum_bcd", {24'd0, bolum_bcd}, 32'd0);
        chk("rst_kalan_bcd", {24'd0, kalan_bcd}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // done held high for 5 cycles: one conversion only
        @(negedge clk);
        bolum = 4'd13; kalan = 4'd2; divisor_zero = 1'b0; done = 1'b1;
        n_valid = 0; n_busy = 0; cap_b = 8'h00; cap_k = 8'h00;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 5) done = 1'b0;
            if (busy) n_busy++;
            if (valid) begin
                n_valid++;
                cap_b = bolum_bcd;
                cap_k = kalan_bcd;
            end
        end
        chk("hold_valid_count", n_valid, 1);
        chk("hold_busy_cycles", n_busy, W + 1);
        chk("hold_bolum_bcd", {24'd0, cap_b}, 32'h13);
        chk("hold_kalan_bcd", {24'd0, cap_k}, 32'h02);

        // second done rise during SHIFT with new operands: ignored
        @(negedge clk);
        bolum = 4'd6; kalan = 4'd4; done = 1'b1;
        n_valid = 0; cap_b = 8'h00; cap_k = 8'h00;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) done = 1'b0;
            if (c == 2) begin bolum = 4'd11; kalan = 4'd7; done = 1'b1; end
            if (c == 3) done = 1'b0;
            if (valid) begin
                n_valid++;
                cap_b = bolum_bcd;
                cap_k = kalan_bcd;
            end
        end
        chk("ovl_valid_count", n_valid, 1);
        chk("ovl_bolum_bcd", {24'd0, cap_b}, 32'h06);
        chk("ovl_kalan_bcd", {24'd0, cap_k}, 32'h04);

        // reset asserted mid-SHIFT
        @(negedge clk);
        bolum = 4'd14; kalan = 4'd1; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bolum_bcd", {24'd0, bolum_bcd}, 32'd0);
        chk("mid_rst_kalan_bcd", {24'd0, kalan_bcd}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        chk("mid_rst_no_valid", n_valid, 0);
        send(4'd14, 4'd1, 1'b0, lat);
        chk("post_rst_valid", {31'd0, valid}, 32'd1);
        chk("post_rst_latency", lat, LAT_OK);
        chk("post_rst_bolum_bcd", {24'd0, bolum_bcd}, 32'h14);
        chk("post_rst_kalan_bcd", {24'd0, kalan_bcd}, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
